pc_ras_unit: RTL and testbench

//   Parametrised program counter with an integrated return-address stack (RAS).

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_ras_unit_if.sv | 33 +++
 rtl/ras_stack.sv | 57 +++++
 rtl/pc_ras_unit.sv | 100 ++++++++++
 tb/tb_pc_ras_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-address stack unit.
// Contents: opcode encodings used on the op bus. Codes 6 and 7 are reserved.
package pc_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_INC    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

endpackage

// File: rtl/pc_ras_unit_if.sv
// Control/status bundle of pc_ras_unit.
// master: drives stall, op, data_in, offset, clr_err; observes pc, RAS status and errors.
// slave : the pc_ras_unit side (mirror of master).
interface pc_ras_unit_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OFF_W = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

    logic               stall;
    logic [2:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [OFF_W-1:0]   offset;
    logic               clr_err;
    logic [WIDTH-1:0]   pc;
    logic [DEPTH_W-1:0] ras_depth;
    logic               ras_full;
    logic               ras_empty;
    logic               err_ovf;
    logic               err_unf;
    logic               err_ill;

    modport master (
        output stall, op, data_in, offset, clr_err,
        input  pc, ras_depth, ras_full, ras_empty, err_ovf, err_unf, err_ill
    );

    modport slave (
        input  stall, op, data_in, offset, clr_err,
        output pc, ras_depth, ras_full, ras_empty, err_ovf, err_unf, err_ill
    );
endinterface

// File: rtl/ras_stack.sv
// Parametrised LIFO holding return addresses.
// Ports: clk, reset (sync, active-high), push/push_data, pop, top (entry at depth-1),
// depth (valid entries), full, empty. Push when full and pop when empty are ignored.
module ras_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W:0]   depth_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        // Push lands at index depth, top lives at depth-1: no wrap pointer needed.
        wr_idx  = depth_q[IDX_W-1:0];
        top_idx = depth_q[IDX_W-1:0] - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + (IDX_W + 1)'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - (IDX_W + 1)'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top   = mem_q[top_idx];
    assign depth = depth_q;
    assign full  = (depth_q == FULL_CNT);
    assign empty = (depth_q == '0);
endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with integrated return-address stack.
// Ports: clk, reset (sync, active-high), bus (slave side of pc_ras_unit_if):
//   inputs stall/op/data_in/offset/clr_err, outputs pc, ras_depth/full/empty and
//   sticky err_ovf/err_unf/err_ill. Holds the next-pc mux, pc register and error flags.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned STEP         = 1,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned OFF_W        = 8
) (
    input logic          clk,
    input logic          reset,
    pc_ras_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VECTOR);

    logic [WIDTH-1:0]         pc_q, pc_d;
    logic                     ovf_q, unf_q, ill_q;
    logic                     ovf_set, unf_set, ill_set;
    logic                     push, pop;
    logic [WIDTH-1:0]         ras_top;
    logic [$clog2(DEPTH):0]   ras_depth;
    logic                     ras_full, ras_empty;
    logic [WIDTH-1:0]         off_ext;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + STEP_W),
        .top       (ras_top),
        .depth     (ras_depth),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        ill_set = 1'b0;
        off_ext = WIDTH'($signed(bus.offset));
        if (!bus.stall) begin
            case (bus.op)
                OP_NOP:    pc_d = pc_q;
                OP_INC:    pc_d = pc_q + STEP_W;
                OP_LOAD:   pc_d = bus.data_in;
                OP_BRANCH: pc_d = pc_q + off_ext;
                OP_CALL: begin
                    // Jump regardless; the stack drops the push itself when full.
                    pc_d    = bus.data_in;
                    push    = 1'b1;
                    ovf_set = ras_full;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pc_d = ras_top;
                        pop  = 1'b1;
                    end
                end
                default:   ill_set = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_W;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            // Set wins over clear when both happen in one cycle.
            ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
            unf_q <= unf_set | (unf_q & ~bus.clr_err);
            ill_q <= ill_set | (ill_q & ~bus.clr_err);
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ras_depth = ras_depth;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;
    assign bus.err_ovf   = ovf_q;
    assign bus.err_unf   = unf_q;
    assign bus.err_ill   = ill_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
module tb_pc_ras_unit;
    import pc_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_ras_unit_if #(.WIDTH(16), .OFF_W(8), .DEPTH(4)) bus ();

    pc_ras_unit #(
        .WIDTH        (16),
        .STEP         (1),
        .RESET_VECTOR (0),
        .DEPTH        (4),
        .OFF_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one op for one cycle, then sample 1 time unit after the edge.
    task automatic do_op(input logic [2:0] o, input logic [15:0] d, input logic [7:0] off,
                         input logic st, input logic clr);
        bus.op      = o;
        bus.data_in = d;
        bus.offset  = off;
        bus.stall   = st;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        bus.op      = OP_NOP;
        bus.stall   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.pc !== 16'h0000 || bus.ras_depth !== 3'd0 || bus.ras_empty !== 1'b1 ||
            bus.ras_full !== 1'b0 || {bus.err_ovf, bus.err_unf, bus.err_ill} !== 3'b000) begin
            errors++;
            $display("FAIL reset: pc=%h depth=%0d empty=%b full=%b err=%b%b%b, need 0000/0/1/0/000",
                     bus.pc, bus.ras_depth, bus.ras_empty, bus.ras_full,
                     bus.err_ovf, bus.err_unf, bus.err_ill);
        end
    endtask

    task automatic test_inc_stall();
        logic [15:0] exp [4] = '{16'hAAAA, 16'hAAAB, 16'hAAAB, 16'hAAAC};
        logic [2:0]  ops [4] = '{OP_LOAD, OP_INC, OP_INC, OP_INC};
        logic        stl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], 16'hAAAA, 8'h00, stl[i], 1'b0);
            checks++;
            if (bus.pc !== exp[i]) begin
                errors++;
                $display("FAIL inc_stall[%0d]: pc=%h need %h", i, bus.pc, exp[i]);
            end
        end
    endtask

    task automatic test_wrap_branch();
        logic [2:0]  ops [5] = '{OP_LOAD, OP_INC, OP_LOAD, OP_BRANCH, OP_BRANCH};
        logic [15:0] dat [5] = '{16'hFFFF, 16'h0, 16'h0010, 16'h0, 16'h0};
        logic [7:0]  off [5] = '{8'h00, 8'h00, 8'h00, 8'hF0, 8'h7F};
        logic [15:0] exp [5] = '{16'hFFFF, 16'h0000, 16'h0010, 16'h0000, 16'h007F};
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], dat[i], off[i], 1'b0, 1'b0);
            checks++;
            if (bus.pc !== exp[i]) begin
                errors++;
                $display("FAIL wrap_branch[%0d]: pc=%h need %h", i, bus.pc, exp[i]);
            end
        end
        // Negative offset wrapping below zero.
        do_op(OP_BRANCH, 16'h0, 8'h80, 1'b0, 1'b0);
        checks++;
        if (bus.pc !== 16'hFFFF) begin
            errors++;
            $display("FAIL branch_neg_wrap: pc=%h need ffff", bus.pc);
        end
    endtask

    task automatic test_call_ret();
        do_op(OP_LOAD, 16'h0100, 8'h00, 1'b0, 1'b0);
        do_op(OP_CALL, 16'h1234, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.pc !== 16'h1234 || bus.ras_depth !== 3'd1 || bus.ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL call: pc=%h depth=%0d empty=%b need 1234/1/0",
                     bus.pc, bus.ras_depth, bus.ras_empty);
        end
        do_op(OP_INC, 16'h0, 8'h00, 1'b0, 1'b0);
        // Stalled RET must not pop.
        do_op(OP_RET, 16'h0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.pc !== 16'h1235 || bus.ras_depth !== 3'd1) begin
            errors++;
            $display("FAIL stall_ret: pc=%h depth=%0d need 1235/1", bus.pc, bus.ras_depth);
        end
        do_op(OP_RET, 16'h0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.pc !== 16'h0101 || bus.ras_depth !== 3'd0 || bus.ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL ret: pc=%h depth=%0d empty=%b need 0101/0/1",
                     bus.pc, bus.ras_depth, bus.ras_empty);
        end
    endtask

    task automatic test_nested();
        logic [15:0] tgt [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
        logic [2:0]  dep [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        // The 5th push (0x41) is dropped, so returns unwind 31, 21, 11, 01.
        logic [15:0] rex [4] = '{16'h0031, 16'h0021, 16'h0011, 16'h0001};
        do_op(OP_LOAD, 16'h0000, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_op(OP_CALL, tgt[i], 8'h00, 1'b0, 1'b0);
            checks++;
            if (bus.pc !== tgt[i] || bus.ras_depth !== dep[i] ||
                bus.ras_full !== (i >= 3) || bus.err_ovf !== (i == 4)) begin
                errors++;
                $display("FAIL nested_call[%0d]: pc=%h depth=%0d full=%b ovf=%b need %h/%0d/%b/%b",
                         i, bus.pc, bus.ras_depth, bus.ras_full, bus.err_ovf,
                         tgt[i], dep[i], (i >= 3), (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_op(OP_RET, 16'h0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (bus.pc !== rex[i] || bus.ras_depth !== 3'(3 - i)) begin
                errors++;
                $display("FAIL nested_ret[%0d]: pc=%h depth=%0d need %h/%0d",
                         i, bus.pc, bus.ras_depth, rex[i], 3 - i);
            end
        end
        do_op(OP_RET, 16'h0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.pc !== 16'h0001 || bus.ras_depth !== 3'd0 || bus.err_unf !== 1'b1 ||
            bus.err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ret_empty: pc=%h depth=%0d unf=%b ovf=%b need 0001/0/1/1",
                     bus.pc, bus.ras_depth, bus.err_unf, bus.err_ovf);
        end
    endtask

    task automatic test_ill_clr_reset();
        // Stalled reserved op is ignored.
        do_op(3'd6, 16'h0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.err_ill !== 1'b0 || bus.pc !== 16'h0001) begin
            errors++;
            $display("FAIL stall_ill: ill=%b pc=%h need 0/0001", bus.err_ill, bus.pc);
        end
        do_op(3'd6, 16'h0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.err_ill !== 1'b1 || bus.pc !== 16'h0001) begin
            errors++;
            $display("FAIL ill: ill=%b pc=%h need 1/0001", bus.err_ill, bus.pc);
        end
        // Set wins over clear: op 7 with clr_err keeps ill set, clears the others.
        do_op(3'd7, 16'h0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({bus.err_ovf, bus.err_unf, bus.err_ill} !== 3'b001) begin
            errors++;
            $display("FAIL set_over_clr: err=%b%b%b need 001",
                     bus.err_ovf, bus.err_unf, bus.err_ill);
        end
        // clr_err honoured even during stall.
        do_op(OP_NOP, 16'h0, 8'h00, 1'b1, 1'b1);
        checks++;
        if ({bus.err_ovf, bus.err_unf, bus.err_ill} !== 3'b000) begin
            errors++;
            $display("FAIL clr_err: err=%b%b%b need 000", bus.err_ovf, bus.err_unf, bus.err_ill);
        end
        do_op(OP_CALL, 16'h0200, 8'h00, 1'b0, 1'b0);
        do_op(OP_CALL, 16'h0300, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.ras_depth !== 3'd2 || bus.pc !== 16'h0300) begin
            errors++;
            $display("FAIL pre_reset: depth=%0d pc=%h need 2/0300", bus.ras_depth, bus.pc);
        end
        do_reset();
        checks++;
        if (bus.pc !== 16'h0000 || bus.ras_depth !== 3'd0 || bus.ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: pc=%h depth=%0d empty=%b need 0000/0/1",
                     bus.pc, bus.ras_depth, bus.ras_empty);
        end
        do_op(OP_RET, 16'h0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.pc !== 16'h0000 || bus.err_unf !== 1'b1) begin
            errors++;
            $display("FAIL ret_after_reset: pc=%h unf=%b need 0000/1", bus.pc, bus.err_unf);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.stall   = 1'b0;
        bus.op      = OP_NOP;
        bus.data_in = '0;
        bus.offset  = '0;
        bus.clr_err = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_inc_stall();
        test_wrap_branch();
        test_call_ret();
        test_nested();
        test_ill_clr_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
